// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle sequencer and its datapath:
// decode/status inputs toward the controller, control word back out.
interface multicycle_control_unit_if #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_src_sel;
  logic             ir_write;
  logic             srca_sel;
  logic [1:0]       srcb_sel;
  logic             aluop;
  logic             alu_out_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src_sel, ir_write, srca_sel, srcb_sel, aluop, alu_out_en,
           iord, mem_read, mem_write, reg_write, mem_to_reg, reg_dst,
           halted, illegal, retired, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src_sel, ir_write, srca_sel, srcb_sel, aluop, alu_out_en,
           iord, mem_read, mem_write, reg_write, mem_to_reg, reg_dst,
           halted, illegal, retired, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle datapath sequencer: one control word per state, memory-ready
// stalls, retired-instruction counter and a terminal HALT state.
module multicycle_control_unit #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16
) (
  input logic                   clock,
  input logic                   reset,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_EXEC_R   = 4'h2,
    S_EXEC_I   = 4'h3,
    S_MEM_ADDR = 4'h4,
    S_MEM_RD   = 4'h5,
    S_MEM_WR   = 4'h6,
    S_WB_MEM   = 4'h7,
    S_WB_ALU   = 4'h8,
    S_BRANCH   = 4'h9,
    S_JUMP     = 4'hA,
    S_HALT     = 4'hB
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next state; retire marks the edge that leaves an instruction's last state.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_ADD, OP_SUB: state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_JMP:         state_d = S_JUMP;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR :
                            (bus.opcode == OP_LW) ? S_MEM_RD : S_FETCH;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_src_sel = 2'd0;
    bus.ir_write   = 1'b0;
    bus.srca_sel   = 1'b0;
    bus.srcb_sel   = 2'd0;
    bus.aluop      = 1'b0;
    bus.alu_out_en = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.halted     = 1'b0;
    bus.illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_en    = bus.mem_ready;
      end
      S_DECODE: begin
        bus.srcb_sel   = 2'd3;
        bus.alu_out_en = 1'b1;
        bus.illegal    = !((bus.opcode < OPC_W'(8)) || (bus.opcode == OP_HALT));
      end
      S_EXEC_R: begin
        bus.srca_sel   = 1'b1;
        bus.srcb_sel   = 2'd1;
        bus.aluop      = bus.opcode[0];
        bus.alu_out_en = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        bus.srca_sel   = 1'b1;
        bus.srcb_sel   = 2'd2;
        bus.alu_out_en = 1'b1;
      end
      S_MEM_RD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
      end
      S_BRANCH: begin
        bus.srca_sel   = 1'b1;
        bus.srcb_sel   = 2'd1;
        bus.aluop      = 1'b1;
        bus.pc_src_sel = 2'd1;
        bus.pc_en      = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
      end
      S_JUMP: begin
        bus.pc_src_sel = 2'd2;
        bus.pc_en      = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
    // Reset overrides the FETCH word so nothing strobes while held.
    if (!reset) begin
      bus.pc_en      = 1'b0;
      bus.ir_write   = 1'b0;
      bus.alu_out_en = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

  assign bus.retired = retired_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a 16-bit-counter instance and a
// 4-bit-counter instance run in lockstep on the same stimulus.
module tb_multicycle_control_unit;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   irw_cnt;

  multicycle_control_unit_if #(.OPC_W(4), .CNT_W(16)) bus ();
  multicycle_control_unit_if #(.OPC_W(4), .CNT_W(4))  bus_w ();

  assign bus_w.opcode    = bus.opcode;
  assign bus_w.zero      = bus.zero;
  assign bus_w.mem_ready = bus.mem_ready;

  multicycle_control_unit #(.OPC_W(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  multicycle_control_unit #(.OPC_W(4), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .bus(bus_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.pc_en, bus.ir_write, bus.alu_out_en, bus.mem_read, bus.mem_write, bus.reg_write};
  endfunction

  initial begin
    logic [3:0] lw_st [10];
    logic       lw_mr [10];
    total = 0;
    bad   = 0;
    lw_st = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h5, 4'h5, 4'h5, 4'h7};
    lw_mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    bus.opcode = 4'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    chk("rst_state", bus.state, 4'h0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_strobes", strobes(), 6'b0);
    cyc();
    cyc();
    chk("rst_hold_state", bus.state, 4'h0);
    reset = 1'b1;
    #1;
    // ADD sweep from release
    chk("rel_fetch_state", bus.state, 4'h0);
    chk("rel_fetch_word", {bus.pc_en, bus.ir_write, bus.mem_read, bus.iord, bus.srcb_sel}, 6'b111000);
    cyc();
    chk("dec_state", bus.state, 4'h1);
    chk("dec_word", {bus.pc_en, bus.alu_out_en, bus.srca_sel, bus.srcb_sel, bus.aluop}, 6'b010110);
    cyc();
    chk("exr_state", bus.state, 4'h2);
    chk("exr_word", {bus.srca_sel, bus.srcb_sel, bus.aluop, bus.alu_out_en}, 5'b10101);
    cyc();
    chk("wba_state", bus.state, 4'h8);
    chk("wba_word", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}, 3'b101);
    chk("wba_retired", bus.retired, 0);
    cyc();
    chk("add1_retired", bus.retired, 1);
    for (int i = 0; i < 8; i++) begin
      chk("sweep_pc_en", bus.pc_en, (bus.state == 4'h0));
      cyc();
    end
    chk("sweep_state", bus.state, 4'h0);
    chk("sweep_retired", bus.retired, 3);

    // SUB then ADDI
    bus.opcode = 4'h1;
    cyc();
    cyc();
    chk("sub_state", bus.state, 4'h2);
    chk("sub_aluop", bus.aluop, 1);
    cyc();
    cyc();
    chk("sub_retired", bus.retired, 4);
    bus.opcode = 4'h2;
    cyc();
    cyc();
    chk("addi_state", bus.state, 4'h3);
    chk("addi_srcb", bus.srcb_sel, 2);
    cyc();
    chk("addi_reg_dst", bus.reg_dst, 0);
    cyc();
    chk("addi_retired", bus.retired, 5);

    // LW with stalls: 3 in FETCH, 2 in MEM_RD -> 10 cycles
    bus.opcode = 4'h3;
    irw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = lw_mr[i];
      #1;
      chk("lw_state", bus.state, lw_st[i]);
      if (lw_st[i] == 4'h0 || lw_st[i] == 4'h5) chk("lw_mem_read", bus.mem_read, 1);
      if (lw_st[i] == 4'h5) chk("lw_iord", bus.iord, 1);
      if (lw_st[i] == 4'h7) chk("lw_wb", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}, 3'b110);
      irw_cnt += int'(bus.ir_write);
      cyc();
    end
    chk("lw_ir_write_pulses", irw_cnt, 1);
    chk("lw_done_state", bus.state, 4'h0);
    chk("lw_retired", bus.retired, 6);

    // Branches
    bus.opcode = 4'h5;
    bus.zero = 1'b1;
    cyc();
    cyc();
    chk("beq1_state", bus.state, 4'h9);
    chk("beq1_word", {bus.pc_en, bus.pc_src_sel, bus.aluop, bus.srca_sel, bus.srcb_sel}, 7'b1011101);
    bus.zero = 1'b0;
    #1;
    chk("beq_mealy_pc_en", bus.pc_en, 0);
    cyc();
    chk("beq1_retired", bus.retired, 7);
    cyc();
    cyc();
    chk("beq0_pc_en", bus.pc_en, 0);
    cyc();
    chk("beq0_retired", bus.retired, 8);
    bus.opcode = 4'h6;
    cyc();
    cyc();
    chk("bne0_pc_en", bus.pc_en, 1);
    cyc();
    chk("bne0_retired", bus.retired, 9);

    // Illegal opcode
    bus.opcode = 4'h9;
    #1;
    chk("ill_fetch_pulse", bus.illegal, 0);
    cyc();
    chk("ill_decode_pulse", bus.illegal, 1);
    cyc();
    chk("ill_back_fetch", bus.state, 4'h0);
    chk("ill_pulse_end", bus.illegal, 0);
    chk("ill_retired", bus.retired, 9);

    // SW, no stall
    bus.opcode = 4'h4;
    cyc();
    cyc();
    chk("sw_addr_state", bus.state, 4'h4);
    cyc();
    chk("sw_wr_word", {bus.state, bus.mem_write, bus.iord}, 6'b011011);
    cyc();
    chk("sw_retired", bus.retired, 10);

    // SW stalled, async reset between edges
    cyc();
    cyc();
    bus.mem_ready = 1'b0;
    cyc();
    cyc();
    chk("sw_stall_state", bus.state, 4'h6);
    chk("sw_stall_mem_write", bus.mem_write, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mem_write", bus.mem_write, 0);
    chk("arst_state", bus.state, 4'h0);
    chk("arst_retired", bus.retired, 0);
    cyc();
    reset = 1'b1;
    bus.mem_ready = 1'b1;

    // HALT
    bus.opcode = 4'hF;
    cyc();
    cyc();
    chk("halt_state", bus.state, 4'hB);
    chk("halt_flag", bus.halted, 1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("halt_hold", {bus.state, bus.halted, strobes()}, {4'hB, 1'b1, 6'b0});
    end
    chk("halt_retired", bus.retired, 0);
    #1;
    reset = 1'b0;
    cyc();
    chk("halt_exit_state", bus.state, 4'h0);
    chk("halt_exit_halted", bus.halted, 0);
    reset = 1'b1;

    // 16 JMPs: 4-bit counter wraps
    bus.opcode = 4'h7;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      cyc();
      chk("jmp_word", {bus_w.state, bus_w.pc_src_sel, bus_w.pc_en}, {4'hA, 2'd2, 1'b1});
      cyc();
      if (n == 15) chk("wrap_pre", bus_w.retired, 15);
    end
    chk("wrap_zero", bus_w.retired, 0);
    chk("jmp16_retired", bus.retired, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
